// File: rtl/counter_ctrl_b_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_ctrl_b_if
// Description : Handshake bundle between the decoder sequencer and the
//               step-by-2 message-memory address counter controller.
//               Bundles request/flow-control inputs and the counter-drive
//               and status outputs of counter_ctrl_b.
//   start       : single-cycle codeword request
//   ready       : downstream accepts an address advance this cycle
//   stop_early  : syndrome check satisfied
//   enable      : counter enable
//   enable0     : 0 = preload 1022, 1 = advance by 2
//   last_beat   : current advance is the final beat of a pass
//   iter        : 0-based index of the pass in progress
//   busy        : controller is processing a codeword
//   done        : one-cycle end-of-codeword pulse
// Modports    : master (requester side), slave (controller side)
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_ctrl_b_if #(
    parameter int ITER_W = 5
);
    logic              start;
    logic              ready;
    logic              stop_early;
    logic              enable;
    logic              enable0;
    logic              last_beat;
    logic [ITER_W-1:0] iter;
    logic              busy;
    logic              done;

    // Requester: issues work and flow control, observes counter drive.
    modport master (
        output start,
        output ready,
        output stop_early,
        input  enable,
        input  enable0,
        input  last_beat,
        input  iter,
        input  busy,
        input  done
    );

    // Controller: consumes requests, drives the counter.
    modport slave (
        input  start,
        input  ready,
        input  stop_early,
        output enable,
        output enable0,
        output last_beat,
        output iter,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/counter_ctrl_b.sv
`default_nettype none
// ============================================================================
// Module      : counter_ctrl_b
// Description : Sequencing controller for the step-by-2 even-address counter
//               of the GF16 NB-LDPC decoder. A start request primes the
//               counter (preload 1022 so the next +2 wraps to 0), then one
//               advance is issued per accepted beat for NUM_PAIRS beats.
//               The pass repeats once per decoding iteration up to MAX_ITER,
//               ending early after the pass in which the check stage reports
//               a valid codeword. Completion is flagged by a done pulse.
// Ports       : clk   - sole clock, rising edge
//               reset - asynchronous, active-low
//               bus   - counter_ctrl_b_if.slave (start/ready/stop_early in,
//                       enable/enable0/last_beat/iter/busy/done out)
// Parameters  : NUM_PAIRS (1..512), MAX_ITER (1..2**ITER_W), ITER_W
// Revision    : 1.0 - initial release
// ============================================================================
module counter_ctrl_b #(
    parameter int NUM_PAIRS = 48,
    parameter int MAX_ITER  = 10,
    parameter int ITER_W    = 5
) (
    input  wire logic        clk,
    input  wire logic        reset,
    counter_ctrl_b_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_BEAT_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(NUM_PAIRS - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_ZERO = '0;
    localparam logic [c_BEAT_W-1:0] c_BEAT_ONE  = c_BEAT_W'(1);
    localparam logic [ITER_W-1:0]   c_ITER_LAST = ITER_W'(MAX_ITER - 1);
    localparam logic [ITER_W-1:0]   c_ITER_ZERO = '0;
    localparam logic [ITER_W-1:0]   c_ITER_ONE  = ITER_W'(1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_PRIME = 3'd1;
    localparam logic [2:0] c_S_RUN   = 3'd2;
    localparam logic [2:0] c_S_GAP   = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [c_BEAT_W-1:0] r_beat;
    logic [ITER_W-1:0]   r_iter;
    logic                r_stop;

    logic [2:0]          w_state_nxt;
    logic [c_BEAT_W-1:0] w_beat_nxt;
    logic [ITER_W-1:0]   w_iter_nxt;
    logic                w_stop_nxt;

    logic                w_busy;
    logic                w_beat_last;
    logic                w_finish;

    assign w_busy      = (r_state != c_S_IDLE);
    assign w_beat_last = (r_beat == c_BEAT_LAST);
    // A stop seen now or earlier in this codeword, or the final allowed pass,
    // ends the codeword at the inter-pass gap.
    assign w_finish    = r_stop | bus.stop_early | (r_iter == c_ITER_LAST);

    // ------------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
            r_beat  <= c_BEAT_ZERO;
            r_iter  <= c_ITER_ZERO;
            r_stop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_iter  <= w_iter_nxt;
            r_stop  <= w_stop_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state and register-update logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_iter_nxt  = r_iter;
        // Sticky: a stop request never truncates the pass in progress, it is
        // remembered and acted on at the next gap.
        w_stop_nxt  = r_stop | (w_busy & bus.stop_early);

        case (r_state)
            c_S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = c_S_PRIME;
                    w_beat_nxt  = c_BEAT_ZERO;
                    w_iter_nxt  = c_ITER_ZERO;
                    w_stop_nxt  = 1'b0;
                end
            end

            // Preload takes exactly one cycle, independent of ready.
            c_S_PRIME: begin
                w_state_nxt = c_S_RUN;
            end

            c_S_RUN: begin
                if (bus.ready) begin
                    if (w_beat_last) begin
                        w_beat_nxt  = c_BEAT_ZERO;
                        w_state_nxt = c_S_GAP;
                    end else begin
                        w_beat_nxt  = r_beat + c_BEAT_ONE;
                    end
                end
            end

            c_S_GAP: begin
                if (w_finish) begin
                    w_state_nxt = c_S_DONE;
                end else begin
                    w_iter_nxt  = r_iter + c_ITER_ONE;
                    w_state_nxt = c_S_PRIME;
                end
            end

            // iter is left untouched so the final pass index stays visible.
            c_S_DONE: begin
                w_state_nxt = c_S_IDLE;
            end

            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: output decode (state plus ready)
    // ------------------------------------------------------------------------
    // enable0 idles at 1 so that leaving reset can never look like a preload.
    always_comb begin
        bus.enable    = 1'b0;
        bus.enable0   = 1'b1;
        bus.last_beat = 1'b0;
        bus.done      = 1'b0;
        bus.busy      = 1'b1;

        case (r_state)
            c_S_IDLE: begin
                bus.busy = 1'b0;
            end

            c_S_PRIME: begin
                bus.enable  = 1'b1;
                bus.enable0 = 1'b0;
            end

            c_S_RUN: begin
                bus.enable    = bus.ready;
                bus.last_beat = bus.ready & w_beat_last;
            end

            c_S_GAP: begin
                bus.enable = 1'b0;
            end

            c_S_DONE: begin
                bus.done = 1'b1;
            end

            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    assign bus.iter = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl_b.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_ctrl_b
// Description : Self-checking bench for counter_ctrl_b. A small instance
//               (4 pairs, 3 iterations) exercises sequencing, flow control,
//               early stop, reset and start filtering; a large instance
//               (512 pairs, 1 iteration) exercises the address ceiling.
//               A behavioural model of the downstream step-by-2 counter turns
//               enable/enable0 into addresses, checked against expected
//               advance events queued when each codeword is requested.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ctrl_b;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    counter_ctrl_b_if #(.ITER_W(5)) s_if ();
    counter_ctrl_b_if #(.ITER_W(5)) l_if ();

    counter_ctrl_b #(.NUM_PAIRS(4), .MAX_ITER(3), .ITER_W(5)) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if.slave)
    );

    counter_ctrl_b #(.NUM_PAIRS(512), .MAX_ITER(1), .ITER_W(5)) u_large (
        .clk   (clk),
        .reset (reset),
        .bus   (l_if.slave)
    );

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------------
    // Downstream address counter model (even addresses, 10 bits)
    // ------------------------------------------------------------------------
    function automatic int cnt_next(input int c, input logic en, input logic en0);
        if (en === 1'b1) begin
            if (en0 === 1'b1) return (c + 2) % 1024;
            return 1022;
        end
        return c;
    endfunction

    int cnt_s = 0;
    int cnt_l = 0;

    always @(posedge clk) begin
        cnt_s <= cnt_next(cnt_s, s_if.enable, s_if.enable0);
        cnt_l <= cnt_next(cnt_l, l_if.enable, l_if.enable0);
    end

    // ------------------------------------------------------------------------
    // Scoreboard of expected counter advances for the small instance
    // ------------------------------------------------------------------------
    typedef struct {
        bit en0;
        bit last;
        int iter;
        int cnt;
    } ev_t;

    ev_t exp_q[$];

    task automatic push_codeword(input int passes);
        for (int p = 0; p < passes; p++) begin
            exp_q.push_back('{1'b0, 1'b0, p, 1022});
            for (int b = 0; b < 4; b++)
                exp_q.push_back('{1'b1, (b == 3), p, 2 * b});
        end
    endtask

    // Runs one codeword on the small instance until its done pulse, checking
    // every advance against the scoreboard. Returns with the DONE cycle still
    // in progress (the next edge leaves DONE).
    task automatic exec(input int ready_mode, input int stop_at, input bit spam,
                        output int lat, output int stalls, output int ndone,
                        output int prime_t);
        int  done_t;
        bit  in_run;
        bit  seen_done;
        bit  rdy;
        int  nxt;
        ev_t e;
        lat = -1; stalls = 0; ndone = 0; prime_t = -1; done_t = -1;
        in_run = 0; seen_done = 0;
        for (int t = 0; t < 300 && !seen_done; t++) begin
            @(negedge clk);
            rdy = (ready_mode == 0) ? 1'b1 : ((t % 2) == 0);
            s_if.start      = (t == 0) || spam;
            s_if.ready      = rdy;
            s_if.stop_early = (t == stop_at);
            #1;
            if (in_run) begin
                checks++;
                if (s_if.enable !== rdy) begin
                    failures++;
                    $display("FAIL run_enable t=%0d: got %b expected %b", t, s_if.enable, rdy);
                end
                if (!rdy) stalls++;
            end
            if (s_if.enable === 1'b1) begin
                nxt = cnt_next(cnt_s, 1'b1, s_if.enable0);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_advance t=%0d: got en0=%b cnt=%0d expected no advance", t, s_if.enable0, nxt);
                end else begin
                    e = exp_q.pop_front();
                    if (s_if.enable0 !== e.en0 || s_if.last_beat !== e.last ||
                        s_if.iter !== 5'(e.iter) || nxt != e.cnt) begin
                        failures++;
                        $display("FAIL sb_event t=%0d: got en0=%b last=%b iter=%0d cnt=%0d expected en0=%b last=%b iter=%0d cnt=%0d",
                                 t, s_if.enable0, s_if.last_beat, s_if.iter, nxt, e.en0, e.last, e.iter, e.cnt);
                    end
                    if (!e.en0) begin
                        in_run = 1;
                        if (prime_t < 0) prime_t = t;
                    end
                    if (e.last) in_run = 0;
                end
            end else begin
                checks++;
                if (s_if.last_beat !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_last_beat t=%0d: got %b expected 0", t, s_if.last_beat);
                end
            end
            if (s_if.done === 1'b1) begin
                ndone++;
                done_t    = t;
                seen_done = 1;
                checks++;
                if (s_if.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL done_busy t=%0d: got %b expected 1", t, s_if.busy);
                end
            end
        end
        checks++;
        if (!seen_done) begin
            failures++;
            $display("FAIL done_timeout: got no done expected done within 300 cycles");
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_advances: got %0d left expected 0", exp_q.size());
        end
        exp_q.delete();
        if (seen_done && prime_t >= 0) lat = done_t - prime_t;
    endtask

    // One idle cycle after a codeword: controller must be back in IDLE.
    task automatic check_idle(input string name, input int exp_iter);
        @(negedge clk);
        s_if.start = 0; s_if.ready = 1; s_if.stop_early = 0;
        #1;
        checks++;
        if (s_if.busy !== 1'b0 || s_if.done !== 1'b0 || s_if.enable !== 1'b0 ||
            s_if.iter !== 5'(exp_iter)) begin
            failures++;
            $display("FAIL %s_idle: got busy=%b done=%b en=%b iter=%0d expected busy=0 done=0 en=0 iter=%0d",
                     name, s_if.busy, s_if.done, s_if.enable, s_if.iter, exp_iter);
        end
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (s_if.enable !== 1'b0 || s_if.enable0 !== 1'b1 || s_if.last_beat !== 1'b0 ||
            s_if.busy !== 1'b0 || s_if.done !== 1'b0 || s_if.iter !== 5'd0) begin
            failures++;
            $display("FAIL reset_state: got en=%b en0=%b last=%b busy=%b done=%b iter=%0d expected 0 1 0 0 0 0",
                     s_if.enable, s_if.enable0, s_if.last_beat, s_if.busy, s_if.done, s_if.iter);
        end
        checks++;
        if (l_if.busy !== 1'b0 || l_if.enable0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_large: got busy=%b en0=%b expected 0 1", l_if.busy, l_if.enable0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int lat, stalls, nd, pt;
        push_codeword(3);
        exec(0, -1, 0, lat, stalls, nd, pt);
        checks++;
        if (lat != 18) begin
            failures++;
            $display("FAIL basic_latency: got %0d expected 18", lat);
        end
        checks++;
        if (nd != 1) begin
            failures++;
            $display("FAIL basic_done_count: got %0d expected 1", nd);
        end
        check_idle("basic", 2);
    endtask

    task automatic test_ready_toggle();
        int lat, stalls, nd, pt;
        push_codeword(3);
        exec(1, -1, 0, lat, stalls, nd, pt);
        checks++;
        if (stalls == 0 || lat != 18 + stalls) begin
            failures++;
            $display("FAIL toggle_latency: got %0d expected %0d (stalls=%0d)", lat, 18 + stalls, stalls);
        end
        check_idle("toggle", 2);
    endtask

    task automatic test_stop_early();
        int lat, stalls, nd, pt;
        push_codeword(1);
        exec(0, 3, 0, lat, stalls, nd, pt);
        checks++;
        if (lat != 6) begin
            failures++;
            $display("FAIL stop_latency: got %0d expected 6", lat);
        end
        check_idle("stop", 0);
    endtask

    task automatic test_busy_start();
        int lat, stalls, nd, pt;
        push_codeword(1);
        exec(0, 2, 1, lat, stalls, nd, pt);
        checks++;
        if (lat != 6 || nd != 1) begin
            failures++;
            $display("FAIL busy_start: got lat=%0d done=%0d expected lat=6 done=1", lat, nd);
        end
    endtask

    // Follows test_busy_start directly: the first cycle here is the IDLE
    // cycle after DONE, so PRIME must appear one cycle later.
    task automatic test_back_to_back();
        int lat, stalls, nd, pt;
        push_codeword(3);
        exec(0, -1, 0, lat, stalls, nd, pt);
        checks++;
        if (pt != 1) begin
            failures++;
            $display("FAIL b2b_prime: got cycle %0d expected 1", pt);
        end
        checks++;
        if (lat != 18) begin
            failures++;
            $display("FAIL b2b_latency: got %0d expected 18", lat);
        end
        check_idle("b2b", 2);
    endtask

    task automatic test_reset_midpass();
        int lat, stalls, nd, pt;
        for (int t = 0; t <= 10; t++) begin
            @(negedge clk);
            s_if.start = (t == 0); s_if.ready = 1; s_if.stop_early = 0;
        end
        #1;
        checks++;
        if (s_if.enable !== 1'b1 || s_if.iter !== 5'd1) begin
            failures++;
            $display("FAIL midpass_pre: got en=%b iter=%0d expected en=1 iter=1", s_if.enable, s_if.iter);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (s_if.enable !== 1'b0 || s_if.enable0 !== 1'b1 || s_if.last_beat !== 1'b0 ||
            s_if.busy !== 1'b0 || s_if.done !== 1'b0 || s_if.iter !== 5'd0) begin
            failures++;
            $display("FAIL async_reset: got en=%b en0=%b last=%b busy=%b done=%b iter=%0d expected 0 1 0 0 0 0",
                     s_if.enable, s_if.enable0, s_if.last_beat, s_if.busy, s_if.done, s_if.iter);
        end
        @(negedge clk);
        reset = 1'b1;
        push_codeword(1);
        exec(0, 2, 0, lat, stalls, nd, pt);
        checks++;
        if (lat != 6) begin
            failures++;
            $display("FAIL post_reset_latency: got %0d expected 6", lat);
        end
        check_idle("post_reset", 0);
    endtask

    task automatic test_large();
        int prime_t, done_t, beats, last_cnt, first_cnt;
        prime_t = -1; done_t = -1; beats = 0; last_cnt = -1; first_cnt = -1;
        for (int t = 0; t < 700 && done_t < 0; t++) begin
            @(negedge clk);
            l_if.start = (t == 0); l_if.ready = 1; l_if.stop_early = 0;
            #1;
            if (l_if.enable === 1'b1) begin
                if (l_if.enable0 === 1'b0 && prime_t < 0) begin
                    prime_t   = t;
                    first_cnt = cnt_next(cnt_l, 1'b1, 1'b0);
                end else if (l_if.enable0 === 1'b1) begin
                    beats++;
                end
                if (l_if.last_beat === 1'b1) last_cnt = cnt_next(cnt_l, 1'b1, l_if.enable0);
            end
            if (l_if.done === 1'b1) done_t = t;
        end
        l_if.start = 0;
        checks++;
        if (first_cnt != 1022) begin
            failures++;
            $display("FAIL large_preload: got %0d expected 1022", first_cnt);
        end
        checks++;
        if (beats != 512) begin
            failures++;
            $display("FAIL large_beats: got %0d expected 512", beats);
        end
        checks++;
        if (last_cnt != 1022) begin
            failures++;
            $display("FAIL large_last_addr: got %0d expected 1022", last_cnt);
        end
        checks++;
        if (done_t < 0 || prime_t < 0 || done_t - prime_t != 514) begin
            failures++;
            $display("FAIL large_latency: got %0d expected 514", done_t - prime_t);
        end
    endtask

    initial begin
        s_if.start = 0; s_if.ready = 1; s_if.stop_early = 0;
        l_if.start = 0; l_if.ready = 1; l_if.stop_early = 0;
        test_reset();
        test_basic();
        test_ready_toggle();
        test_stop_early();
        test_busy_start();
        test_back_to_back();
        test_reset_midpass();
        test_large();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
